mac_pipe_sat: RTL and testbench
===============================

# mac_pipe_sat

Parametrised pipelined signed multiply-accumulate unit for the MAC datapath family. It generalises the fixed 14-bit, fixed-stage MAC in three ways: configurable operand width, configurable multiplier pipeline depth, and an accumulator-restart control that travels through the pipeline with its data. It sits between the operand source (valid-qualified a/b stream) and the result consumer, which samples `f` when `valid_out` is high.

## Interface
Parameters:
- `W`, 14, signed operand width (range 4–32)
- `ACC_W`, 2*W, accumulator/result width (must be ≥ 2*W)
- `PIPE_STAGES`, 2, multiplier register stages after the input registers (range 1–6)

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-low reset; sampled on rising edge of `clk`
- `a`  input  W  signed operand A
- `b`  input  W  signed operand B
- `valid_in`  input  1  a/b/clr qualified this cycle
- `clr`  input  1  with `valid_in`: this product starts a new accumulation
- `f`  output  ACC_W  signed accumulated result
- `valid_out`  output  1  `f` updated at the preceding edge
- `ovf`  output  1  sticky: overflow occurred since last restart

## Operation
- Reset (`reset`=0 at edge): `f`=0, `valid_out`=0, `ovf`=0; all pipeline valid and clr bits = 0. Data registers may also be cleared; this is not required.
- Input stage: when `valid_in`=1, registers `a`, `b`, and `clr`. Operand registers hold when `valid_in`=0. A valid bit always registers `valid_in`.
- Multiplier: a full-precision signed W×W product is sign-extended to ACC_W. It is carried through `PIPE_STAGES` registers. A valid/clr shift register of identical depth runs alongside the product, so bubbles and back-to-back inputs are both supported.
- Accumulate stage: acts only when the pipeline-tail valid bit is 1.
  - Tail clr=1: `f` ← product (no addition), `ovf` ← 0.
  - Tail clr=0: `f` ← `f` + product, with the overflow rule below.
  - Tail valid=0: `f` and `ovf` hold.
- Overflow detection: both addends have the same sign and the raw sum has the opposite sign.
  - Positive overflow → MAX = 2^(ACC_W-1)-1.
  - Negative overflow → MIN = -2^(ACC_W-1).
  - On detection, `ovf` ← 1 (sticky).
- Product alone never overflows, because ACC_W ≥ 2W. The one exception is W×W (-2^(W-1))² = 2^(2W-2), which fits.
- `valid_out` = registered tail valid bit. It is high for exactly one cycle per accepted input.

## Timing
- Latency: an input sampled at edge k updates `f` and asserts `valid_out` at edge k+PIPE_STAGES+1.
- Throughput: one input per cycle, sustained indefinitely. There is no back-pressure.
- Data ordering: in-order. Each output corresponds 1:1 to an accepted input.
- clr applies to its own product only. Results issued before the clr are unaffected. A clr on consecutive inputs produces consecutive fresh results.
- Reset mid-operation: in-flight inputs are discarded. `valid_out`=0 from the next edge until PIPE_STAGES+1 edges after the first post-reset valid input.
- `valid_in` during reset: ignored.
- Simultaneous clr and overflow-causing data: the clr takes precedence. `f` ← product and `ovf` ← 0.

## Configuration
- `MAC_SAT_EN` defined: saturating accumulate as specified above.
- `MAC_SAT_EN` undefined: `f` wraps modulo 2^ACC_W. Overflow detection is still performed and `ovf` still sets sticky on wrap. No clamp logic is built.

## Test plan
(Defaults: W=14, ACC_W=28, PIPE_STAGES=2.)
- Latency/basic: reset, then one valid input a=3, b=4, clr=1 at edge 0 → `valid_out`=1 and `f`=12 after edge 3; `valid_out`=0 after edge 4.
- Back-to-back with bubble: (2,5,clr=1), (−3,7), gap, (100,−100) → `f` sequence 10, −11, −10011, each on its own `valid_out` pulse; `f` holds across the gap.
- Positive saturation (`MAC_SAT_EN` defined): (−8192,−8192,clr=1), (−8192,−8192) → `f`=0x4000000, then 0x7FFFFFF with `ovf`=1. A further (1,1) keeps `f`=0x7FFFFFF. Then (1,1,clr=1) → `f`=1, `ovf`=0.
- Negative saturation and wrap mode: (−8192,8191,clr=1) repeated without clr until overflow → `f`=0x8000000 (MIN) with `ovf`=1. With `MAC_SAT_EN` undefined, the same sequence wraps to a positive value and `ovf`=1.
- Reset mid-flight: issue 3 valid inputs, assert `reset`=0 for one edge after the second → `f`=0, `valid_out`=0, `ovf`=0. No `valid_out` pulse appears for the discarded inputs.
- Parameter sweep: PIPE_STAGES=1 and 6, W=8/ACC_W=16, random stream → outputs match the reference model at latency PIPE_STAGES+1, including clr placement and saturation.

Source files
------------

// File: rtl/mac_pipe_sat.sv
// mac_pipe_sat: parametrised pipelined signed multiply-accumulate unit.
//
// Operands are captured in an input register stage. Their full-precision
// product then travels through PIPE_STAGES registers. Alongside it runs a
// valid/clr shift register of the same depth, so each restart request stays
// aligned with its own product. The accumulate stage either restarts from
// the tail product or adds it to the running sum.
//
// Optional feature macro: MAC_SAT_EN
//   defined   -> the accumulator clamps to MAX/MIN on signed overflow
//   undefined -> the accumulator wraps modulo 2^ACC_W
// In both builds overflow is detected and reported on the sticky ovf flag.
//
// Reset is synchronous and active-low.
module mac_pipe_sat #(
   parameter int W           = 14,
   parameter int ACC_W       = 2*W,
   parameter int PIPE_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [W-1:0]     a,
   input  logic signed [W-1:0]     b,
   input  logic                    valid_in,
   input  logic                    clr,
   output logic signed [ACC_W-1:0] f,
   output logic                    valid_out,
   output logic                    ovf
);

   // Input stage: operands and clr are only captured with valid_in
   logic signed [W-1:0]     a_q;
   logic signed [W-1:0]     b_q;
   logic                    clr_q;
   logic                    valid_q;

   // Multiplier: full-precision product, sign-extended to the accumulator width
   logic signed [2*W-1:0]   prod_full;
   logic signed [ACC_W-1:0] prod_ext;

   // Product pipeline plus the matching valid/clr control pipeline
   logic signed [ACC_W-1:0] prod_pipe [PIPE_STAGES];
   logic [PIPE_STAGES-1:0]  valid_pipe;
   logic [PIPE_STAGES-1:0]  clr_pipe;

   // Pipeline tail, seen by the accumulate stage
   logic signed [ACC_W-1:0] tail_prod;
   logic                    tail_valid;
   logic                    tail_clr;

   // Accumulate datapath
   logic signed [ACC_W-1:0] raw_sum;
   logic signed [ACC_W-1:0] acc_next;
   logic                    pos_ovf;
   logic                    neg_ovf;

`ifdef MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   // Capture operands and clr with valid_in; the valid bit tracks valid_in every cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q     <= '0;
         b_q     <= '0;
         clr_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_in;
         if (valid_in) begin
            a_q   <= a;
            b_q   <= b;
            clr_q <= clr;
         end
      end
   end

   // Both operands are widened to 2W first, so the signed product cannot be
   // truncated. This includes (-2^(W-1))^2, which needs all 2W bits.
   assign prod_full = (2*W)'(a_q) * (2*W)'(b_q);
   assign prod_ext  = ACC_W'(prod_full);

   // Shift the product and its valid/clr tags down the multiplier pipeline together
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_pipe <= '0;
         clr_pipe   <= '0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            prod_pipe[i] <= '0;
         end
      end else begin
         prod_pipe[0]  <= prod_ext;
         valid_pipe[0] <= valid_q;
         clr_pipe[0]   <= clr_q;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            prod_pipe[i]  <= prod_pipe[i-1];
            valid_pipe[i] <= valid_pipe[i-1];
            clr_pipe[i]   <= clr_pipe[i-1];
         end
      end
   end

   assign tail_prod  = prod_pipe[PIPE_STAGES-1];
   assign tail_valid = valid_pipe[PIPE_STAGES-1];
   assign tail_clr   = clr_pipe[PIPE_STAGES-1];

   // Add the tail product to the running sum and detect signed overflow.
   // Overflow means both addends have the same sign but the sum has the other sign.
   always_comb begin
      raw_sum  = f + tail_prod;
      pos_ovf  = !f[ACC_W-1] && !tail_prod[ACC_W-1] &&  raw_sum[ACC_W-1];
      neg_ovf  =  f[ACC_W-1] &&  tail_prod[ACC_W-1] && !raw_sum[ACC_W-1];
      acc_next = raw_sum;
`ifdef MAC_SAT_EN
      if (pos_ovf) begin
         acc_next = ACC_MAX;
      end else if (neg_ovf) begin
         acc_next = ACC_MIN;
      end
`endif
   end

   // Accumulate stage: restart on tail clr, otherwise add; hold on bubbles
   always_ff @(posedge clk) begin
      if (!reset) begin
         f         <= '0;
         valid_out <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         valid_out <= tail_valid;
         if (tail_valid) begin
            if (tail_clr) begin
               f   <= tail_prod;
               ovf <= 1'b0;
            end else begin
               f <= acc_next;
               if (pos_ovf || neg_ovf) begin
                  ovf <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_pipe_sat.sv
// tb_mac_pipe_sat: self-checking bench for mac_pipe_sat.
// Directed scenarios run on the default configuration (W=14, ACC_W=28,
// PIPE_STAGES=2). A random stream is driven into three instances: the default
// one, plus W=8/ACC_W=16 instances with PIPE_STAGES=1 and PIPE_STAGES=6.
// Each instance is checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_pipe_sat;

   localparam int MAXN = 64;
`ifdef MAC_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] a0, b0;
   logic [7:0]  a8, b8;
   logic        valid_in, clr;
   logic [27:0] f0;
   logic [15:0] f1, f2;
   logic        vo0, vo1, vo2, ov0, ov1, ov2;

   int checks = 0;
   int errors = 0;

   // Per-edge stimulus; in_rst=1 means reset is asserted at that edge
   logic [13:0] in_a [MAXN];
   logic [13:0] in_b [MAXN];
   bit          in_v [MAXN];
   bit          in_clr [MAXN];
   bit          in_rst [MAXN];

   // Per-edge observations, sampled 1ns after each rising edge
   bit     obs_v [3][MAXN];
   bit     obs_o [3][MAXN];
   longint obs_f [3][MAXN];

   always #5 clk = ~clk;

   mac_pipe_sat #(.W(14), .ACC_W(28), .PIPE_STAGES(2)) dut0 (
      .clk(clk), .reset(reset), .a(a0), .b(b0), .valid_in(valid_in), .clr(clr),
      .f(f0), .valid_out(vo0), .ovf(ov0));

   mac_pipe_sat #(.W(8), .ACC_W(16), .PIPE_STAGES(1)) dut1 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .valid_in(valid_in), .clr(clr),
      .f(f1), .valid_out(vo1), .ovf(ov1));

   mac_pipe_sat #(.W(8), .ACC_W(16), .PIPE_STAGES(6)) dut2 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .valid_in(valid_in), .clr(clr),
      .f(f2), .valid_out(vo2), .ovf(ov2));

   // Reference model: one accumulate step on mathematical integers
   function automatic void ref_step(inout longint acc, inout bit ov,
                                    input longint prod, input bit c, input int accw);
      longint lim;
      longint sum;
      lim = longint'(1) <<< (accw - 1);
      if (c) begin
         acc = prod;
         ov  = 1'b0;
      end else begin
         sum = acc + prod;
         if (sum > lim - 1) begin
            ov  = 1'b1;
            acc = SAT ? (lim - 1) : (sum - 2 * lim);
         end else if (sum < -lim) begin
            ov  = 1'b1;
            acc = SAT ? -lim : (sum + 2 * lim);
         end else begin
            acc = sum;
         end
      end
   endfunction

   function automatic longint sx(input logic [13:0] v, input int w);
      if (w == 8) return longint'($signed(v[7:0]));
      return longint'($signed(v));
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < MAXN; i++) begin
         in_a[i] = '0; in_b[i] = '0; in_v[i] = 0; in_clr[i] = 0; in_rst[i] = 0;
      end
   endtask

   // Drive n stimulus cycles followed by drain idle cycles, recording outputs per edge
   task automatic drive_burst(input int n, input int drain);
      for (int e = 0; e < n + drain; e++) begin
         if (e < n) begin
            reset = !in_rst[e]; valid_in = in_v[e]; clr = in_clr[e];
            a0 = in_a[e]; b0 = in_b[e];
         end else begin
            reset = 1'b1; valid_in = 1'b0; clr = 1'b0; a0 = '0; b0 = '0;
         end
         a8 = a0[7:0]; b8 = b0[7:0];
         @(posedge clk); #1;
         obs_v[0][e] = vo0; obs_o[0][e] = ov0; obs_f[0][e] = longint'($signed(f0));
         obs_v[1][e] = vo1; obs_o[1][e] = ov1; obs_f[1][e] = longint'($signed(f1));
         obs_v[2][e] = vo2; obs_o[2][e] = ov2; obs_f[2][e] = longint'($signed(f2));
      end
   endtask

   // Reset with valid_in asserted: outputs clear and no pulse ever follows
   task automatic test_reset();
      clear_stim();
      for (int i = 0; i < 2; i++) begin
         in_rst[i] = 1; in_v[i] = 1; in_clr[i] = 1; in_a[i] = 14'd5; in_b[i] = 14'd5;
      end
      drive_burst(2, 4);
      for (int e = 0; e < 6; e++) begin
         checks++;
         if (obs_v[0][e] !== 1'b0) begin
            errors++; $display("[TB] FAIL reset valid_out edge %0d: got %0d expected 0", e, obs_v[0][e]);
         end
         checks++;
         if (obs_f[0][e] !== 0) begin
            errors++; $display("[TB] FAIL reset f edge %0d: got %0d expected 0", e, obs_f[0][e]);
         end
         checks++;
         if (obs_o[0][e] !== 1'b0) begin
            errors++; $display("[TB] FAIL reset ovf edge %0d: got %0d expected 0", e, obs_o[0][e]);
         end
      end
   endtask

   // Single input (3,4,clr): result 12 appears at edge 3 as a one-cycle pulse
   task automatic test_latency();
      longint exp_f;
      bit     exp_v;
      clear_stim();
      in_v[0] = 1; in_clr[0] = 1; in_a[0] = 14'd3; in_b[0] = 14'd4;
      drive_burst(1, 5);
      for (int e = 0; e < 6; e++) begin
         exp_v = (e == 3);
         exp_f = (e >= 3) ? 12 : 0;
         checks++;
         if (obs_v[0][e] !== exp_v) begin
            errors++; $display("[TB] FAIL latency valid_out edge %0d: got %0d expected %0d", e, obs_v[0][e], exp_v);
         end
         checks++;
         if (obs_f[0][e] !== exp_f) begin
            errors++; $display("[TB] FAIL latency f edge %0d: got %0d expected %0d", e, obs_f[0][e], exp_f);
         end
      end
   endtask

   // Back-to-back inputs with a bubble: f holds across the gap
   task automatic test_back_to_back();
      longint exp_f [8] = '{12, 12, 12, 10, -11, -11, -10011, -10011};
      bit     exp_v [8] = '{0, 0, 0, 1, 1, 0, 1, 0};
      clear_stim();
      in_v[0] = 1; in_clr[0] = 1; in_a[0] = 14'd2;      in_b[0] = 14'd5;
      in_v[1] = 1;                in_a[1] = 14'(-3);    in_b[1] = 14'd7;
      in_v[3] = 1;                in_a[3] = 14'd100;    in_b[3] = 14'(-100);
      drive_burst(4, 4);
      for (int e = 0; e < 8; e++) begin
         checks++;
         if (obs_v[0][e] !== exp_v[e]) begin
            errors++; $display("[TB] FAIL b2b valid_out edge %0d: got %0d expected %0d", e, obs_v[0][e], exp_v[e]);
         end
         checks++;
         if (obs_f[0][e] !== exp_f[e]) begin
            errors++; $display("[TB] FAIL b2b f edge %0d: got %0d expected %0d", e, obs_f[0][e], exp_f[e]);
         end
      end
   endtask

   // Positive overflow: clamps to MAX (or wraps), ovf sticky, clr restarts
   task automatic test_pos_sat();
      longint exp_f [5] = '{67108864,
                            SAT ? 134217727 : -134217728,
                            SAT ? 134217727 : -134217727,
                            1, 1};
      bit     exp_o [5] = '{0, 1, 1, 0, 0};
      clear_stim();
      for (int i = 0; i < 4; i++) begin
         in_v[i] = 1;
         in_a[i] = (i < 2) ? 14'(-8192) : 14'd1;
         in_b[i] = (i < 2) ? 14'(-8192) : 14'd1;
      end
      in_clr[0] = 1; in_clr[3] = 1;
      drive_burst(4, 4);
      for (int e = 0; e < 8; e++) begin
         checks++;
         if (obs_v[0][e] !== (e >= 3 && e <= 6)) begin
            errors++; $display("[TB] FAIL possat valid_out edge %0d: got %0d", e, obs_v[0][e]);
         end
      end
      for (int e = 3; e < 8; e++) begin
         checks++;
         if (obs_f[0][e] !== exp_f[e-3]) begin
            errors++; $display("[TB] FAIL possat f edge %0d: got %0d expected %0d", e, obs_f[0][e], exp_f[e-3]);
         end
         checks++;
         if (obs_o[0][e] !== exp_o[e-3]) begin
            errors++; $display("[TB] FAIL possat ovf edge %0d: got %0d expected %0d", e, obs_o[0][e], exp_o[e-3]);
         end
      end
   endtask

   // Negative overflow: clamps to MIN, or wraps to a positive value
   task automatic test_neg_sat();
      longint exp_f [3] = '{-67100672, -134201344, SAT ? -134217728 : 67133440};
      bit     exp_o [3] = '{0, 0, 1};
      clear_stim();
      for (int i = 0; i < 3; i++) begin
         in_v[i] = 1; in_a[i] = 14'(-8192); in_b[i] = 14'd8191;
      end
      in_clr[0] = 1;
      drive_burst(3, 4);
      for (int e = 3; e < 6; e++) begin
         checks++;
         if (obs_v[0][e] !== 1'b1) begin
            errors++; $display("[TB] FAIL negsat valid_out edge %0d: got %0d expected 1", e, obs_v[0][e]);
         end
         checks++;
         if (obs_f[0][e] !== exp_f[e-3]) begin
            errors++; $display("[TB] FAIL negsat f edge %0d: got %0d expected %0d", e, obs_f[0][e], exp_f[e-3]);
         end
         checks++;
         if (obs_o[0][e] !== exp_o[e-3]) begin
            errors++; $display("[TB] FAIL negsat ovf edge %0d: got %0d expected %0d", e, obs_o[0][e], exp_o[e-3]);
         end
      end
   endtask

   // Reset after two in-flight inputs: both are discarded, the post-reset input survives
   task automatic test_reset_midflight();
      bit     exp_v;
      longint exp_f;
      clear_stim();
      in_v[0] = 1; in_clr[0] = 1; in_a[0] = 14'd5; in_b[0] = 14'd6;
      in_v[1] = 1;                in_a[1] = 14'd7; in_b[1] = 14'd8;
      in_rst[2] = 1; in_v[2] = 1; in_clr[2] = 1; in_a[2] = 14'd9; in_b[2] = 14'd9;
      in_v[3] = 1;                in_a[3] = 14'd2; in_b[3] = 14'd3;
      drive_burst(4, 4);
      for (int e = 0; e < 8; e++) begin
         exp_v = (e == 6);
         checks++;
         if (obs_v[0][e] !== exp_v) begin
            errors++; $display("[TB] FAIL midreset valid_out edge %0d: got %0d expected %0d", e, obs_v[0][e], exp_v);
         end
         if (e >= 2) begin
            exp_f = (e >= 6) ? 6 : 0;
            checks++;
            if (obs_f[0][e] !== exp_f) begin
               errors++; $display("[TB] FAIL midreset f edge %0d: got %0d expected %0d", e, obs_f[0][e], exp_f);
            end
            checks++;
            if (obs_o[0][e] !== 1'b0) begin
               errors++; $display("[TB] FAIL midreset ovf edge %0d: got %0d expected 0", e, obs_o[0][e]);
            end
         end
      end
   endtask

   // Random stream into all three instances, compared per edge with the reference model
   task automatic test_param_sweep();
      int     n = 48;
      int     total = 56;
      int     pipe [3] = '{2, 1, 6};
      int     accw [3] = '{28, 16, 16};
      int     wid  [3] = '{14, 8, 8};
      longint acc;
      bit     ov;
      bit     exp_v;
      int     src;
      clear_stim();
      in_rst[0] = 1;
      for (int i = 1; i < n; i++) begin
         in_v[i]   = ($urandom_range(0, 3) != 0);
         in_clr[i] = ($urandom_range(0, 5) == 0);
         in_a[i]   = 14'($urandom);
         in_b[i]   = 14'($urandom);
      end
      drive_burst(n, total - n);
      for (int d = 0; d < 3; d++) begin
         acc = 0;
         ov  = 1'b0;
         for (int e = 0; e < total; e++) begin
            src   = e - pipe[d] - 1;
            exp_v = (src >= 1) && (src < n) && in_v[src];
            if (exp_v) begin
               ref_step(acc, ov, sx(in_a[src], wid[d]) * sx(in_b[src], wid[d]), in_clr[src], accw[d]);
            end
            checks++;
            if (obs_v[d][e] !== exp_v) begin
               errors++; $display("[TB] FAIL sweep dut%0d valid_out edge %0d: got %0d expected %0d", d, e, obs_v[d][e], exp_v);
            end
            checks++;
            if (obs_f[d][e] !== acc) begin
               errors++; $display("[TB] FAIL sweep dut%0d f edge %0d: got %0d expected %0d", d, e, obs_f[d][e], acc);
            end
            checks++;
            if (obs_o[d][e] !== ov) begin
               errors++; $display("[TB] FAIL sweep dut%0d ovf edge %0d: got %0d expected %0d", d, e, obs_o[d][e], ov);
            end
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      reset = 1'b0; valid_in = 1'b0; clr = 1'b0;
      a0 = '0; b0 = '0; a8 = '0; b8 = '0;
      test_reset();
      test_latency();
      test_back_to_back();
      test_pos_sat();
      test_neg_sat();
      test_reset_midflight();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
